riscvctrl_axil_arbiter: RTL and testbench

- Shares the single AXI4-Lite slave port of the RISC-V control register block (4 x 32-bit registers at 0x0/0x4/0x8/0xC) between two requesters, one per core.
- Each requester uses a simple req/ack register-access interface. The block arbitrates round-robin and runs exactly one AXI4-Lite transaction at a time on the master side.
- Sits between the dual-core cluster and the control IP, on the same clock.

---
 rtl/riscvctrl_axil_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_riscvctrl_axil_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscvctrl_axil_arbiter.sv
// riscvctrl_axil_arbiter: shares the control-register AXI4-Lite slave
// between two req/ack requesters, round-robin, one transaction at a time.
//
// Ports:
//   ACLK, ARESET        clock, asynchronous active-high reset
//   req, we             per-requester request and write/read select
//   addr, wdata         per-requester command, slice i = requester i
//   ack                 one-cycle completion pulse per requester
//   rdata, err          last read data, response error (valid with ack)
//   M_AXI_AW*/W*/B*     AXI4-Lite write channels (master side)
//   M_AXI_AR*/R*        AXI4-Lite read channels (master side)
module riscvctrl_axil_arbiter #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic          last_gnt;
  logic          gnt;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          aw_q;
  logic          w_q;
  logic          ar_q;
  logic          b_q;
  logic          r_q;
  logic [1:0]    ack_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          b_hs;
  logic          r_hs;
  logic          aw_open;
  logic          w_open;
  logic          grant_now;
  logic          addr_done;
  logic          resp_done;

  // Word-aligned bus: byte-offset and response-low bits are don't-care.
  logic          unused_bits;
  assign unused_bits = ^{M_AXI_BRESP[0], M_AXI_RRESP[0],
                         addr[AW+1:AW], addr[1:0]};

  // Contention goes to whoever was not granted last.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req == 2'b11): win = ~last_gnt;
      (req == 2'b10): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

  assign win_we    = win ? we[1] : we[0];
  assign win_addr  = win ? addr[AW +: AW] : addr[0 +: AW];
  assign win_wdata = win ? wdata[DW +: DW] : wdata[0 +: DW];

  assign aw_hs   = aw_q & M_AXI_AWREADY;
  assign w_hs    = w_q & M_AXI_WREADY;
  assign ar_hs   = ar_q & M_AXI_ARREADY;
  assign b_hs    = b_q & M_AXI_BVALID;
  assign r_hs    = r_q & M_AXI_RVALID;
  assign aw_open = aw_q & ~M_AXI_AWREADY;
  assign w_open  = w_q & ~M_AXI_WREADY;

  assign grant_now = (state == S_IDLE) & (|req);

  // A write leaves ADDR only when neither AW nor W is still pending.
  assign addr_done = (state == S_ADDR) &
                     (cmd_we ? (~aw_open & ~w_open) : ar_hs);

  assign resp_done = (state == S_RESP) &
                     (cmd_we ? b_hs : r_hs);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (|req) state <= S_ADDR;
        S_ADDR:  if (addr_done) state <= S_RESP;
        S_RESP:  if (resp_done) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // last_gnt resets to 1 so the first contended grant goes to 0.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
    end else if (grant_now) begin
      last_gnt <= win;
      gnt      <= win;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant_now) begin
      cmd_we    <= win_we;
      cmd_addr  <= {win_addr[AW-1:2], 2'b00};
      cmd_wdata <= win_wdata;
    end
  end

  // VALIDs are pure registers; each drops on its own handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_q <= 1'b0;
      w_q  <= 1'b0;
      ar_q <= 1'b0;
    end else if (grant_now) begin
      aw_q <= win_we;
      w_q  <= win_we;
      ar_q <= ~win_we;
    end else begin
      if (aw_hs) aw_q <= 1'b0;
      if (w_hs)  w_q  <= 1'b0;
      if (ar_hs) ar_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      b_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      if (addr_done) begin
        b_q <= cmd_we;
        r_q <= ~cmd_we;
      end
      if (b_hs) b_q <= 1'b0;
      if (r_hs) r_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (resp_done) begin
      err_q <= cmd_we ? M_AXI_BRESP[1]
                      : M_AXI_RRESP[1];
      if (!cmd_we) rdata_q <= M_AXI_RDATA;
    end
  end

  // ack is high exactly during DONE.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ack_q <= 2'b00;
    end else begin
      ack_q <= 2'b00;
      if (resp_done) ack_q <= gnt ? 2'b10 : 2'b01;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

  assign M_AXI_AWADDR  = cmd_addr;
  assign M_AXI_AWVALID = aw_q;
  assign M_AXI_WDATA   = cmd_wdata;
  assign M_AXI_WVALID  = w_q;
  assign M_AXI_BREADY  = b_q;
  assign M_AXI_ARADDR  = cmd_addr;
  assign M_AXI_ARVALID = ar_q;
  assign M_AXI_RREADY  = r_q;

endmodule

// File: tb/tb_riscvctrl_axil_arbiter.sv
// tb_riscvctrl_axil_arbiter: scoreboard bench with an AXI4-Lite slave
// model and a register-level reference model of the two requesters.
module tb_riscvctrl_axil_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]      ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic [AW-1:0]   awaddr;
  logic [AW-1:0]   araddr;
  logic            awvalid, awready, wvalid, wready;
  logic            bvalid, bready, arvalid, arready;
  logic            rvalid, rready;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      bresp;
  logic [1:0]      rresp;

  always #5 ACLK = ~ACLK;

  riscvctrl_axil_arbiter #(.AW(AW), .DW(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // ---------------- slave model ----------------
  logic [31:0]   smem [4];
  int            aw_dly = 0, w_dly = 0, b_dly = 0;
  int            ar_dly = 0, r_dly = 0;
  bit            inject = 1'b0;
  int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic          got_aw, got_w, rd_pend;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [31:0]   s_wdata;

  assign awready = awvalid && !got_aw && aw_cnt >= aw_dly;
  assign wready  = wvalid && !got_w && w_cnt >= w_dly;
  assign bvalid  = got_aw && got_w && b_cnt >= b_dly;
  assign bresp   = (inject && s_awaddr[3:2] == 2'd3) ? 2'b10 : 2'b00;
  assign arready = arvalid && !rd_pend && ar_cnt >= ar_dly;
  assign rvalid  = rd_pend && r_cnt >= r_dly;
  assign m_rdata = smem[s_araddr[3:2]];
  assign rresp   = (inject && s_araddr[3:2] == 2'd3) ? 2'b10 : 2'b00;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      got_aw <= 0; got_w <= 0; rd_pend <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      ar_cnt <= 0; r_cnt <= 0;
      s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready && !got_aw) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready && !got_w) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready && !rd_pend) ? ar_cnt + 1 : 0;
      if (awready) begin got_aw <= 1; s_awaddr <= awaddr; end
      if (wready) begin got_w <= 1; s_wdata <= m_wdata; end
      if (got_aw && got_w && !bvalid) b_cnt <= b_cnt + 1;
      if (bvalid && bready) begin
        got_aw <= 0; got_w <= 0; b_cnt <= 0;
        if (bresp == 2'b00) smem[s_awaddr[3:2]] <= s_wdata;
      end
      if (arready) begin
        rd_pend <= 1; s_araddr <= araddr; r_cnt <= 0;
      end else if (rd_pend && !rvalid) begin
        r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) begin rd_pend <= 0; r_cnt <= 0; end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          id;
    logic [31:0] rd;
    bit          er;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [4];
  logic [31:0] m_last_rd = '0;
  int          m_last_gnt = 1;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_op(input int id, input bit w,
                          input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    logic [1:0] wd;
    bit er;
    wd = a[3:2];
    er = inject && (wd == 2'd3);
    if (w) begin
      if (!er) mmem[wd] = d;
    end else begin
      m_last_rd = mmem[wd];
    end
    e.id = id;
    e.rd = m_last_rd;
    e.er = er;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  int t_valid = -1, t_bready = -1, t_ack = -1;
  int aw_hi = 0, w_hi = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    exp_t e;
    logic [1:0] ea;
    if (!ARESET) begin
      if ((awvalid || arvalid) && t_valid < 0) t_valid = cyc;
      if ((bready || rready) && t_bready < 0) t_bready = cyc;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid && awready) chk("awaddr_align", awaddr[1:0], 0);
      if (arvalid && arready) chk("araddr_align", araddr[1:0], 0);
      if (ack != 2'b00) begin
        t_ack = cyc;
        if (q.size() == 0) begin
          chk("unexpected_ack", ack, 0);
        end else begin
          e = q.pop_front();
          ea = (e.id == 1) ? 2'b10 : 2'b01;
          chk("ack_id", ack, ea);
          chk("rdata", rdata, e.rd);
          chk("err", err, e.er);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int start = 0;

  task automatic run_round(input bit [1:0] p, input bit [1:0] w,
                           input logic [7:0] a, input logic [63:0] d);
    int first, second, n;
    bit [1:0] done;
    if (p == 2'b11) begin
      first = (m_last_gnt == 1) ? 0 : 1;
      second = 1 - first;
      model_op(first, w[first], a[first*4 +: 4], d[first*32 +: 32]);
      model_op(second, w[second], a[second*4 +: 4], d[second*32 +: 32]);
      m_last_gnt = second;
    end else begin
      first = p[1] ? 1 : 0;
      model_op(first, w[first], a[first*4 +: 4], d[first*32 +: 32]);
      m_last_gnt = first;
    end
    t_valid = -1; t_bready = -1; t_ack = -1;
    aw_hi = 0; w_hi = 0;
    start = cyc;
    we = w; addr = a; wdata = d; req = p;
    done = ~p;
    n = 0;
    while (done != 2'b11 && n < 300) begin
      @(negedge ACLK);
      n++;
      if (ack[0]) done[0] = 1'b1;
      if (ack[1]) done[1] = 1'b1;
      @(posedge ACLK);
      #1;
      if (done[0]) req[0] = 1'b0;
      if (done[1]) req[1] = 1'b0;
    end
    if (n >= 300) chk("round_timeout", 1, 0);
    req = 2'b00;
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic run_continuous(input int total);
    int cur, got, n;
    logic [7:0] a;
    a = 8'h84;
    cur = (m_last_gnt == 1) ? 0 : 1;
    for (int k = 0; k < total; k++) begin
      model_op(cur, 1'b0, a[cur*4 +: 4], 32'h0);
      m_last_gnt = cur;
      cur = 1 - cur;
    end
    we = 2'b00; addr = a; req = 2'b11;
    got = 0; n = 0;
    while (got < total && n < 400) begin
      @(negedge ACLK);
      n++;
      if (ack != 2'b00) got++;
    end
    if (n >= 400) chk("cont_timeout", 1, 0);
    @(posedge ACLK);
    #1;
    req = 2'b00;
    chk("cont_drained", q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valids"}, {awvalid, wvalid, arvalid}, 0);
    chk({tag, "_readies"}, {bready, rready}, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit [1:0] p, w;
    logic [7:0] a;
    logic [63:0] d;
    for (int i = 0; i < 4; i++) begin
      smem[i] = '0;
      mmem[i] = '0;
    end
    #1 ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_reset_outputs("reset");
    @(posedge ACLK);
    #1 ARESET = 1'b0;

    // contention in the first IDLE cycle: requester 0 first
    run_round(2'b11, 2'b11, 8'h84, {32'h3, 32'h2});
    run_round(2'b11, 2'b00, 8'h84, 64'h0);

    // zero-wait latency, write then read
    run_round(2'b01, 2'b01, 8'h00, {32'h0, 32'h1});
    chk("wr_lat_valid", t_valid - start, 1);
    chk("wr_lat_bready", t_bready - start, 2);
    chk("wr_lat_ack", t_ack - start, 3);
    run_round(2'b01, 2'b00, 8'h00, 64'h0);
    chk("rd_lat_ack", t_ack - start, 3);

    // continuous reads alternate
    run_continuous(6);

    // slow AWREADY
    aw_dly = 3;
    run_round(2'b10, 2'b10, 8'h40, {32'h5A5A0001, 32'h0});
    chk("aw_held", aw_hi, 4);
    chk("w_held", w_hi, 1);
    chk("bready_after_aw", t_bready - t_valid, 4);
    chk("aw_slow_ack", t_ack - start, 6);
    aw_dly = 0;

    // error response then OKAY clears err
    run_round(2'b01, 2'b01, 8'h0C, {32'h0, 32'hCAFE0003});
    inject = 1'b1;
    run_round(2'b01, 2'b00, 8'h0C, 64'h0);
    run_round(2'b01, 2'b00, 8'h00, 64'h0);
    run_round(2'b01, 2'b00, 8'h0C, 64'h0);

    // reset while waiting in RESP
    b_dly = 8;
    we = 2'b01; addr = 8'h04; wdata = {32'h0, 32'hDEAD0000};
    req = 2'b01;
    n = 0;
    while (!bready && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("reached_resp", bready, 1);
    #1 ARESET = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    req = 2'b00;
    inject = 1'b0;
    b_dly = 0;
    m_last_gnt = 1;
    m_last_rd = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    run_round(2'b11, 2'b11, 8'h40, {32'h11, 32'h22});
    run_round(2'b11, 2'b00, 8'h04, 64'h0);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      p = 2'($urandom_range(1, 3));
      w = 2'($urandom);
      a = 8'($urandom);
      d = {$urandom, $urandom};
      aw_dly = $urandom_range(0, 3);
      w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      inject = ($urandom_range(0, 3) == 0);
      run_round(p, w, a, d);
    end

    repeat (3) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
